// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared state encoding and stream-format constants for the imem boot loader.
package imem_boot_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERR} state_e;
    localparam int LEN_BYTES  = 2;
    localparam int CSUM_WIDTH = 8;
    localparam int CNT_BITS   = LEN_BYTES * 8;
    function automatic int max_words(input int addr_width);
        return 1 << (addr_width - 2);
    endfunction
endpackage

// File: rtl/imem_boot_loader_packer.sv
// byte_word_packer: shifts bytes first-to-MSB into 32-bit words and flags the byte completing a word.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;
    // The completed word is presented combinationally so the top can register the write on the same edge.
    assign word       = {shift_q, in_byte};
    assign word_valid = in_valid && cnt_q == 2'd3;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (in_valid) begin
            shift_q <= {shift_q[15:0], in_byte};
            cnt_q   <= cnt_q + 2'd1;
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: parses a length-prefixed byte stream, writes packed words into imem,
// verifies an XOR checksum and holds the CPU until a good image is loaded.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = 10,
    parameter int CNT_WIDTH       = CNT_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic                       imem_we,
    output logic [31:0]                imem_waddr,
    output logic [31:0]                imem_wdata,
    output logic                       cpu_hold,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [IMEM_ADDR_WIDTH-2:0] words_loaded
);
    localparam logic [CNT_WIDTH-1:0] MAX_N = CNT_WIDTH'(max_words(IMEM_ADDR_WIDTH));

    state_e                     state_q;
    logic [7:0]                 len_hi_q;
    logic [CNT_WIDTH-1:0]       len_q;
    logic [CSUM_WIDTH-1:0]      csum_q;
    logic [IMEM_ADDR_WIDTH-2:0] words_q;
    logic [IMEM_ADDR_WIDTH-2:0] words_d;
    logic [31:0]                waddr_q;
    logic [31:0]                wdata_q;
    logic                       we_q;
    logic                       hold_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       err_q;
    logic [CNT_WIDTH-1:0]       len_in;
    logic                       can_start;
    logic                       accept;
    logic                       pack_valid;
    logic [31:0]                word;
    logic                       word_valid;

    assign rx_ready     = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
    assign can_start    = start && state_q inside {S_IDLE, S_DONE, S_ERR};
    assign accept       = rx_valid && rx_ready;
    assign pack_valid   = accept && state_q == S_DATA;
    assign len_in       = CNT_WIDTH'({len_hi_q, rx_data});
    assign words_d      = words_q + 1'b1;
    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

    byte_word_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (can_start),
        .in_valid  (pack_valid),
        .in_byte   (rx_data),
        .word      (word),
        .word_valid(word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            csum_q   <= '0;
            words_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: if (start) begin
                    state_q <= S_LEN_HI;
                    csum_q  <= '0;
                    words_q <= '0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    hold_q  <= 1'b1;
                    busy_q  <= 1'b1;
                end
                S_LEN_HI: if (accept) begin
                    len_hi_q <= rx_data;
                    state_q  <= S_LEN_LO;
                end
                S_LEN_LO: if (accept) begin
                    len_q <= len_in;
                    if (len_in > MAX_N) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= len_in == '0 ? S_CHECK : S_DATA;
                    end
                end
                S_DATA: if (accept) begin
                    csum_q <= csum_q ^ rx_data;
                    if (word_valid) begin
                        we_q    <= 1'b1;
                        waddr_q <= 32'({words_q[IMEM_ADDR_WIDTH-3:0], 2'b00});
                        wdata_q <= word;
                        words_q <= words_d;
                        if (CNT_WIDTH'(words_d) == len_q) state_q <= S_CHECK;
                    end
                end
                S_CHECK: if (accept) begin
                    busy_q <= 1'b0;
                    if (rx_data == csum_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        hold_q  <= 1'b0;
                    end else begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized sessions checked against a stream-level model of the loader.
module tb_imem_boot_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, imem_we, cpu_hold, busy, done, err;
    logic [31:0] imem_waddr, imem_wdata;
    logic [8:0]  words_loaded;
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  stream[$];
    logic [31:0] got_addr[$], got_data[$], exp_addr[$], exp_data[$];
    bit          exp_done;
    int          exp_words;

    imem_boot_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_addr.push_back(imem_waddr);
            got_data.push_back(imem_wdata);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1);
    end

    task automatic make_stream(input int n, input bit bad);
        logic [15:0] len;
        logic [7:0]  b;
        logic [7:0]  c;
        len = 16'(n);
        c = 8'h00;
        stream.delete();
        stream.push_back(len[15:8]);
        stream.push_back(len[7:0]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            c ^= b;
        end
        stream.push_back(bad ? ~c : c);
    endtask

    task automatic model();
        int n;
        logic [7:0] c;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        n = int'({stream[0], stream[1]});
        exp_words = 0;
        exp_done = 1'b0;
        c = 8'h00;
        if (n > 256) return;
        for (int i = 0; i < n; i++) begin
            w = {stream[2 + 4 * i], stream[3 + 4 * i], stream[4 + 4 * i], stream[5 + 4 * i]};
            exp_addr.push_back(32'(4 * i));
            exp_data.push_back(w);
            c ^= w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        exp_words = n;
        exp_done = stream[2 + 4 * n] == c;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        t = 0;
        while (rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        if (t >= 20) begin
            tests++;
            fails++;
            $display("FAIL rx_ready timeout: got %b want 1", rx_ready);
        end
    endtask

    task automatic run_session(input string name, input int maxgap, input int start_at);
        model();
        got_addr.delete();
        got_data.delete();
        start = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        rx_valid = 1'b0;
        tests++;
        if ({cpu_hold, busy, done, err} !== 4'b1100) begin
            fails++;
            $display("FAIL %s start hold/busy/done/err: got %b want 1100", name, {cpu_hold, busy, done, err});
        end
        for (int i = 0; i < stream.size(); i++) begin
            if (i == start_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(stream[i], int'($urandom_range(0, maxgap)));
        end
        tests++;
        if (got_addr.size() != exp_addr.size()) begin
            fails++;
            $display("FAIL %s write count: got %0d want %0d", name, got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            tests++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                fails++;
                $display("FAIL %s write %0d: got %h:%h want %h:%h", name, i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            end
        end
        tests++;
        if ({done, err, cpu_hold, busy, rx_ready} !== {exp_done, !exp_done, !exp_done, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL %s status done/err/hold/busy/ready: got %b want %b", name,
                     {done, err, cpu_hold, busy, rx_ready}, {exp_done, !exp_done, !exp_done, 1'b0, 1'b0});
        end
        tests++;
        if (words_loaded !== 9'(exp_words)) begin
            fails++;
            $display("FAIL %s words_loaded: got %0d want %0d", name, words_loaded, exp_words);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, err, words_loaded} !== '0) begin
            fails++;
            $display("FAIL reset outputs: got %b/%h/%h/%b%b%b%b/%0d want all zero", {rx_ready, imem_we},
                     imem_waddr, imem_wdata, cpu_hold, busy, done, err, words_loaded);
        end
        rst = 1'b0;
        rx_valid = 1'b1;
        rx_data = 8'h55;
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
        tests++;
        if ({rx_ready, imem_we, cpu_hold, busy, done, err, words_loaded} !== '0) begin
            fails++;
            $display("FAIL idle ignores bytes: got %b want all zero", {rx_ready, imem_we, cpu_hold, busy, done, err, words_loaded});
        end
    endtask

    task automatic test_load_n2();
        stream = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h10, 8'h01, 8'h34, 8'h3D, 8'h00, 8'h04, 8'h21};
        run_session("load_n2", 0, -1);
        tests++;
        if (got_data.size() != 2 || got_data[0] !== 32'h3C011001 || got_data[1] !== 32'h343D0004 || done !== 1'b1) begin
            fails++;
            $display("FAIL load_n2 literal words: got %0d words done=%b want 3C011001,343D0004 done=1", got_data.size(), done);
        end
    endtask

    task automatic test_bad_checksum();
        stream = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h10, 8'h01, 8'h34, 8'h3D, 8'h00, 8'h04, 8'h00};
        run_session("bad_checksum", 0, -1);
    endtask

    task automatic test_oversize();
        stream = '{8'h01, 8'h01};
        run_session("oversize_257", 1, -1);
        stream = '{8'hFF, 8'hFF};
        run_session("oversize_ffff", 0, -1);
    endtask

    task automatic test_zero_len();
        stream = '{8'h00, 8'h00, 8'h00};
        run_session("zero_len", 0, -1);
        stream = '{8'h00, 8'h00, 8'h01};
        run_session("zero_len_bad", 0, -1);
    endtask

    task automatic test_max_len();
        make_stream(256, 1'b0);
        run_session("max_len", 0, -1);
    endtask

    task automatic test_gapped_start_mid();
        for (int s = 0; s < 4; s++) begin
            make_stream(int'($urandom_range(1, 8)), 1'b0);
            run_session("gapped", 3, int'($urandom_range(0, 6)));
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 6; s++) begin
            make_stream(int'($urandom_range(1, 6)), bit'($urandom_range(0, 1)));
            run_session("back_to_back", 0, -1);
        end
    endtask

    task automatic test_reset_mid();
        make_stream(3, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
        rst = 1'b1;
        #1;
        tests++;
        if ({rx_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, busy, done, err, words_loaded} !== '0) begin
            fails++;
            $display("FAIL reset_mid outputs: got %b/%h/%h/%b%b%b%b/%0d want all zero", {rx_ready, imem_we},
                     imem_waddr, imem_wdata, cpu_hold, busy, done, err, words_loaded);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        make_stream(3, 1'b0);
        run_session("after_reset", 1, -1);
    endtask

    initial begin
        test_reset();
        test_load_n2();
        test_bad_checksum();
        test_oversize();
        test_zero_len();
        test_max_len();
        test_gapped_start_mid();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
